// File: rtl/pipe_hazard_unit_if.sv
// Hazard-unit signal bundle: pipeline-stage hazard inputs and the
// forward/stall/flush/statistics outputs. The pipeline side is the master.
interface pipe_hazard_unit_if;
  logic       PCSrcE, PCSrc, RegWrite, MemtoRegE, BranchTakenE, PCSrcD;
  logic [3:0] WA3E, RA1D, RA2D, RA1E, RA2E;
  logic       StatClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount, FlushCount;

  modport master (
    output PCSrcE, PCSrc, RegWrite, MemtoRegE, BranchTakenE, PCSrcD,
           WA3E, RA1D, RA2D, RA1E, RA2E, StatClr,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );

  modport slave (
    input  PCSrcE, PCSrc, RegWrite, MemtoRegE, BranchTakenE, PCSrcD,
           WA3E, RA1D, RA2D, RA1E, RA2E, StatClr,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           StallCount, FlushCount
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard unit: E-stage operand forwarding from M/W, load-use stall,
// PC-write stall/flush, and saturating stall/flush statistics counters.
module phu_fwd (
  input  logic [3:0] ra,
  input  logic       reg_write_m,
  input  logic [3:0] wa3_m,
  input  logic       reg_write_w,
  input  logic [3:0] wa3_w,
  output logic [1:0] fwd
);
  // R15 is the PC; its writes are never forwarded. M wins over W.
  always_comb begin
    fwd = 2'b00;
    if (reg_write_m && ra == wa3_m && wa3_m != 4'hF)      fwd = 2'b10;
    else if (reg_write_w && ra == wa3_w && wa3_w != 4'hF) fwd = 2'b01;
  end
endmodule

module pipe_hazard_unit (
  input logic             clk,
  input logic             reset,
  pipe_hazard_unit_if.slave hz
);
  localparam int STAGES = 2;   // M, W
  localparam int NUM_OPS = 2;  // A, B operands

  typedef struct packed {
    logic       reg_write;
    logic [3:0] wa3;
    logic       pc_src;
  } wb_t;

  wb_t              wb_e;
  wb_t [STAGES:1]   wb_pipe;  // [1]=M, [2]=W

  assign wb_e = '{reg_write: hz.RegWrite, wa3: hz.WA3E, pc_src: hz.PCSrc};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_pipe <= '0;
    end else begin
      wb_pipe[1] <= wb_e;
      wb_pipe[2] <= wb_pipe[1];
    end
  end

  logic [NUM_OPS-1:0][3:0] ra_e;
  logic [NUM_OPS-1:0][1:0] fwd;
  assign ra_e = {hz.RA2E, hz.RA1E};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
    phu_fwd u_fwd (
      .ra          (ra_e[i]),
      .reg_write_m (wb_pipe[1].reg_write),
      .wa3_m       (wb_pipe[1].wa3),
      .reg_write_w (wb_pipe[2].reg_write),
      .wa3_w       (wb_pipe[2].wa3),
      .fwd         (fwd[i])
    );
  end

  assign hz.ForwardAE = fwd[0];
  assign hz.ForwardBE = fwd[1];

  logic ldr_stall, pc_wr_pending;

  assign ldr_stall = hz.MemtoRegE && hz.RegWrite && hz.WA3E != 4'hF &&
                     (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
  assign pc_wr_pending = hz.PCSrcD | hz.PCSrcE | wb_pipe[1].pc_src;

  assign hz.StallF = ldr_stall | pc_wr_pending;
  assign hz.StallD = ldr_stall;
  assign hz.FlushD = pc_wr_pending | wb_pipe[2].pc_src | hz.BranchTakenE;
  assign hz.FlushE = ldr_stall | hz.BranchTakenE;

  logic [15:0] stall_cnt, flush_cnt;

  // Clear beats increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (hz.StatClr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.StallF && stall_cnt != 16'hFFFF)                 stall_cnt <= stall_cnt + 16'd1;
      if ((hz.FlushD || hz.FlushE) && flush_cnt != 16'hFFFF)  flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed self-checking bench for pipe_hazard_unit: forwarding, load-use,
// PC-write sequencing, branch priority, counter saturation/clear, async reset.
module tb_pipe_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  pipe_hazard_unit_if hz ();

  pipe_hazard_unit dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    hz.PCSrcE = 0; hz.PCSrc = 0; hz.RegWrite = 0; hz.MemtoRegE = 0;
    hz.BranchTakenE = 0; hz.PCSrcD = 0; hz.WA3E = 0; hz.RA1D = 0;
    hz.RA2D = 0; hz.RA1E = 0; hz.RA2E = 0; hz.StatClr = 0;
  endtask

  // Advance one edge, land 1 time unit after it.
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic stat_clear;
    hz.StatClr = 1; tick(); hz.StatClr = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 0;
    #12;
    checks++; if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
      failures++; $display("FAIL reset_fwd got A=%b B=%b exp 00", hz.ForwardAE, hz.ForwardBE); end
    checks++; if (hz.StallCount !== 16'd0 || hz.FlushCount !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got %h/%h exp 0/0", hz.StallCount, hz.FlushCount); end
    checks++; if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctl got %b exp 0000", {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}); end
    // Control still combinational during reset
    hz.MemtoRegE = 1; hz.RegWrite = 1; hz.WA3E = 4'd5; hz.RA1D = 4'd5; #1;
    checks++; if ({hz.StallF, hz.StallD, hz.FlushD, hz.FlushE} !== 4'b1101) begin
      failures++; $display("FAIL reset_ldr_ctl got %b exp 1101", {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}); end
    clear_inputs();
    @(negedge clk); reset = 1;
    tick();
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    hz.RegWrite = 1; hz.WA3E = 4'd3;
    tick();
    hz.RegWrite = 0; hz.RA1E = 4'd3; hz.RA2E = 4'd3; #1;
    checks++; if (hz.ForwardAE !== 2'b10) begin
      failures++; $display("FAIL b2b_c1_A got %b exp 10", hz.ForwardAE); end
    checks++; if (hz.ForwardBE !== 2'b10) begin
      failures++; $display("FAIL b2b_c1_B got %b exp 10", hz.ForwardBE); end
    tick(); #1;
    checks++; if (hz.ForwardAE !== 2'b01) begin
      failures++; $display("FAIL b2b_c2_A got %b exp 01", hz.ForwardAE); end
    tick(); #1;
    checks++; if (hz.ForwardAE !== 2'b00) begin
      failures++; $display("FAIL b2b_c3_A got %b exp 00", hz.ForwardAE); end
  endtask

  task automatic test_m_priority;
    clear_inputs();
    hz.RegWrite = 1; hz.WA3E = 4'd7;
    tick(); tick();
    hz.RegWrite = 0; hz.RA1E = 4'd7; hz.RA2E = 4'd6; #1;
    checks++; if (hz.ForwardAE !== 2'b10 || hz.ForwardBE !== 2'b00) begin
      failures++; $display("FAIL m_prio got A=%b B=%b exp 10/00", hz.ForwardAE, hz.ForwardBE); end
    tick(); tick();
  endtask

  task automatic test_r15;
    clear_inputs();
    hz.RegWrite = 1; hz.WA3E = 4'hF;
    tick();
    hz.RA1E = 4'hF; hz.RA2E = 4'hF; #1;
    checks++; if (hz.ForwardAE !== 2'b00 || hz.ForwardBE !== 2'b00) begin
      failures++; $display("FAIL r15_fwd got A=%b B=%b exp 00", hz.ForwardAE, hz.ForwardBE); end
    tick();
    hz.RegWrite = 0; hz.WA3E = 4'hF; hz.MemtoRegE = 1; hz.RegWrite = 1; hz.RA1D = 4'hF; #1;
    checks++; if (hz.StallD !== 1'b0 || hz.FlushE !== 1'b0) begin
      failures++; $display("FAIL r15_ldr got StallD=%b FlushE=%b exp 0/0", hz.StallD, hz.FlushE); end
    clear_inputs(); tick(); tick();
  endtask

  task automatic test_load_use;
    clear_inputs(); tick(); tick();
    stat_clear();
    hz.MemtoRegE = 1; hz.RegWrite = 1; hz.WA3E = 4'd5; hz.RA2D = 4'd5; #1;
    checks++; if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD} !== 4'b1110) begin
      failures++; $display("FAIL ldr_ctl got %b exp 1110", {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD}); end
    tick();
    checks++; if (hz.StallCount !== 16'd1 || hz.FlushCount !== 16'd1) begin
      failures++; $display("FAIL ldr_cnt got %h/%h exp 1/1", hz.StallCount, hz.FlushCount); end
    // Clear overrides a same-cycle increment
    hz.StatClr = 1; tick(); hz.StatClr = 0;
    checks++; if (hz.StallCount !== 16'd0 || hz.FlushCount !== 16'd0) begin
      failures++; $display("FAIL clr_override got %h/%h exp 0/0", hz.StallCount, hz.FlushCount); end
    clear_inputs(); tick(); tick();
  endtask

  task automatic test_pc_write;
    logic [1:0] exp_sf_fd [0:4];
    exp_sf_fd[0] = 2'b11; exp_sf_fd[1] = 2'b11; exp_sf_fd[2] = 2'b11;
    exp_sf_fd[3] = 2'b01; exp_sf_fd[4] = 2'b00;
    clear_inputs();
    stat_clear();
    for (int c = 0; c < 5; c++) begin
      hz.PCSrcD = (c == 0);
      hz.PCSrcE = (c == 1);
      hz.PCSrc  = (c == 1);
      #1;
      checks++; if ({hz.StallF, hz.FlushD} !== exp_sf_fd[c]) begin
        failures++; $display("FAIL pcwr_c%0d got StallF,FlushD=%b exp %b", c, {hz.StallF, hz.FlushD}, exp_sf_fd[c]); end
      tick();
    end
    checks++; if (hz.StallCount !== 16'd3 || hz.FlushCount !== 16'd4) begin
      failures++; $display("FAIL pcwr_cnt got %h/%h exp 3/4", hz.StallCount, hz.FlushCount); end
    clear_inputs();
  endtask

  task automatic test_branch_load;
    clear_inputs(); tick(); tick();
    stat_clear();
    hz.MemtoRegE = 1; hz.RegWrite = 1; hz.WA3E = 4'd5; hz.RA2D = 4'd5; hz.BranchTakenE = 1; #1;
    checks++; if ({hz.FlushD, hz.FlushE, hz.StallD, hz.StallF} !== 4'b1111) begin
      failures++; $display("FAIL br_ldr_ctl got %b exp 1111", {hz.FlushD, hz.FlushE, hz.StallD, hz.StallF}); end
    tick();
    checks++; if (hz.FlushCount !== 16'd1) begin
      failures++; $display("FAIL br_ldr_cnt got %h exp 1", hz.FlushCount); end
    clear_inputs(); tick(); tick();
  endtask

  task automatic test_counter_sat;
    clear_inputs();
    stat_clear();
    hz.PCSrcD = 1;
    repeat (65540) @(posedge clk);
    #1;
    checks++; if (hz.StallCount !== 16'hFFFF) begin
      failures++; $display("FAIL sat_stall got %h exp FFFF", hz.StallCount); end
    checks++; if (hz.FlushCount !== 16'hFFFF) begin
      failures++; $display("FAIL sat_flush got %h exp FFFF", hz.FlushCount); end
    hz.StatClr = 1; tick(); hz.StatClr = 0;
    checks++; if (hz.StallCount !== 16'd0 || hz.FlushCount !== 16'd0) begin
      failures++; $display("FAIL sat_clr got %h/%h exp 0/0", hz.StallCount, hz.FlushCount); end
    clear_inputs(); tick(); tick();
  endtask

  task automatic test_async_reset;
    clear_inputs();
    hz.RegWrite = 1; hz.WA3E = 4'd2; hz.RA1E = 4'd2;
    tick(); #1;
    checks++; if (hz.ForwardAE !== 2'b10) begin
      failures++; $display("FAIL async_pre got %b exp 10", hz.ForwardAE); end
    #2 reset = 0; #1;
    checks++; if (hz.ForwardAE !== 2'b00) begin
      failures++; $display("FAIL async_drop got %b exp 00", hz.ForwardAE); end
    @(negedge clk); reset = 1;
    tick(); #1;
    checks++; if (hz.ForwardAE !== 2'b10) begin
      failures++; $display("FAIL async_reload got %b exp 10", hz.ForwardAE); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_m_priority();
    test_r15();
    test_load_use();
    test_pc_write();
    test_branch_load();
    test_async_reset();
    test_counter_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
